hack_mem_ctrl: RTL and testbench
================================

// Module: hack_mem_ctrl
// PURPOSE
//  Hack data-memory controller downstream of the 4-way load demux: decodes the
//  CPU data address into RAM (0x0000-0x3FFF), SCREEN (0x4000-0x5FFF) and KBD
//  (0x6000). Drives the external 24K-word block RAM, mirrors screen writes into
//  a write FIFO for the video framebuffer, and holds the keyboard register.
// PARAMETERS
//  FIFO_DEPTH   4         screen-write FIFO entries (power of 2, >=2)
//  SCREEN_BASE  15'h4000  first screen word address
//  KBD_ADDR     15'h6000  keyboard register address
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  cpu_addr    in   15  CPU data address (addressM)
//  cpu_wdata   in   16  CPU write data (outM)
//  cpu_we      in   1   CPU write strobe (writeM)
//  cpu_rdata   out  16  read data (inM), registered
//  cpu_stall   out  1   CPU must hold addr/data/we this cycle
//  ram_addr    out  15  block RAM address (= cpu_addr)
//  ram_wdata   out  16  block RAM write data
//  ram_we      out  1   block RAM write enable
//  ram_rdata   in   16  block RAM read data, 1-cycle latency
//  fb_addr     out  13  screen word offset (cpu_addr - SCREEN_BASE)
//  fb_data     out  16  screen pixel word
//  fb_valid    out  1   FIFO head valid
//  fb_ready    in   1   video side accepts head
//  kbd_code    in   16  Hack key code from keyboard decoder (0 = no key)
//  kbd_valid   in   1   1-cycle strobe: load kbd_code
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset is asynchronous, active-low (rst_n).
//  Reset: cpu_rdata=0, kbd_reg=0, FIFO empty, fb_valid=0, cpu_stall=0,
//   rd_region=NONE. Reset mid-operation discards queued FIFO entries.
//  Decode (combinational, 2-bit region from cpu_addr[14:13] plus KBD compare):
//   00/01 RAM; 10 SCREEN; cpu_addr==KBD_ADDR KBD; other 11xx NONE.
//  Writes (cpu_we=1):
//   RAM: ram_we=1 same cycle.
//   SCREEN, FIFO not full: ram_we=1 and FIFO push {offset,data} same cycle.
//   SCREEN, FIFO full: cpu_stall=1, ram_we=0, no push; retried next cycle.
//    Full is judged before this cycle's pop (no write-through when full).
//   KBD / NONE: dropped, ram_we=0, no stall.
//  cpu_stall is combinational, asserted only for screen write with FIFO full.
//  Reads: rd_region registered every cycle; cpu_rdata valid cycle N+1 for
//   address in cycle N: RAM/SCREEN -> ram_rdata, KBD -> kbd_reg, NONE -> 0.
//  Keyboard: kbd_valid=1 loads kbd_reg<=kbd_code; read of KBD in the same
//   cycle returns the previous kbd_reg value.
//  FIFO: head popped when fb_valid&&fb_ready; push and pop same cycle when
//   not full: count unchanged, order preserved. Pointers wrap modulo FIFO_DEPTH
//   with one extra bit for full/empty. fb_valid = !empty; fb_addr/fb_data
//   stable while fb_valid&&!fb_ready.
// STRUCTURE
//  Shared package/header: region encoding (RGN_RAM, RGN_SCREEN, RGN_KBD,
//   RGN_NONE), SCREEN_BASE, KBD_ADDR, word width 16, address width 15.
//  One sub-module: hack_wr_fifo (sync FIFO, width 29, depth FIFO_DEPTH,
//   push/pop/full/empty, async active-low reset).
//  Top: decoder, kbd_reg, rd_region register, read mux.
// TESTING
//  1 Reset: rst_n low mid-write with 2 FIFO entries -> fb_valid=0,
//    cpu_rdata=0, kbd_reg=0 immediately (async), no ram_we after release.
//  2 Write 16'h1234 @0x0010, read 0x0010 -> ram_we pulse, no push;
//    cpu_rdata=16'h1234 one cycle after read address.
//  3 fb_ready=0, 5 writes to 0x4000..0x4004 -> 4 pushes, 5th cycle
//    cpu_stall=1 ram_we=0; raise fb_ready -> pops offsets 0,1,2,3 then 4 in order.
//  4 kbd_valid with 16'd65, read 0x6000 same cycle -> 0; next read -> 65;
//    write 0x6000 -> kbd_reg unchanged, ram_we=0.
//  5 Read 0x6001 and 0x7FFF -> cpu_rdata=0; writes there -> no ram_we, no stall.
//  6 Steady fb_ready=1 with back-to-back screen writes -> never stalls,
//    one-entry occupancy, simultaneous push/pop keeps count constant.

Source files
------------

// File: rtl/hack_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hack_mem_ctrl_pkg
//   Shared definitions for the Hack data-memory controller: bus widths,
//   default memory-map constants, the region encoding and the address decoder.
// -----------------------------------------------------------------------------
package hack_mem_ctrl_pkg;

  localparam int WORD_W    = 16;                // Hack data word
  localparam int ADDR_W    = 15;                // Hack data address
  localparam int FB_ADDR_W = 13;                // screen word offset (8K words)
  localparam int FIFO_W    = FB_ADDR_W + WORD_W; // {offset, data} = 29 bits

  localparam logic [ADDR_W-1:0] DEF_SCREEN_BASE = 15'h4000;
  localparam logic [ADDR_W-1:0] DEF_KBD_ADDR    = 15'h6000;

  typedef enum logic [1:0] {
    RGN_RAM    = 2'd0,
    RGN_SCREEN = 2'd1,
    RGN_KBD    = 2'd2,
    RGN_NONE   = 2'd3
  } region_e;

  // The keyboard compare takes precedence; otherwise the top two address
  // bits select RAM (00/01), SCREEN (10) or unmapped (11).
  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] kbd_addr);
    region_e rgn;
    rgn = RGN_NONE;
    if (addr == kbd_addr) begin
      rgn = RGN_KBD;
    end else begin
      case (addr[ADDR_W-1:ADDR_W-2])
        2'b00, 2'b01: rgn = RGN_RAM;
        2'b10:        rgn = RGN_SCREEN;
        default:      rgn = RGN_NONE;
      endcase
    end
    return rgn;
  endfunction

endpackage

// File: rtl/hack_wr_fifo.sv
// -----------------------------------------------------------------------------
// hack_wr_fifo
//   Synchronous FIFO carrying screen writes to the video framebuffer.
//   Pointers carry one extra wrap bit so full and empty are distinguished
//   without a separate counter.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   i_push      write i_data (ignored while full)
//   i_data      entry to store
//   i_pop       remove head (ignored while empty)
//   o_data      head entry, stable until popped
//   o_full      no free entry
//   o_empty     no stored entry
// -----------------------------------------------------------------------------
module hack_wr_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[PW-1:0]];

  // Storage needs no reset: an entry is only visible once a push wrote it.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/hack_mem_ctrl.sv
// -----------------------------------------------------------------------------
// hack_mem_ctrl
//   Hack data-memory controller. Decodes the CPU data address into RAM,
//   SCREEN and KBD, drives the external block RAM, mirrors screen writes into
//   a FIFO for the video side and holds the keyboard register.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_addr/wdata/we     CPU data address, write data, write strobe
//   cpu_rdata             read data, valid the cycle after the address
//   cpu_stall             CPU must hold its request (screen write, FIFO full)
//   ram_addr/wdata/we     block RAM request
//   ram_rdata             block RAM read data, one-cycle latency
//   fb_addr/fb_data       FIFO head: screen word offset and pixel word
//   fb_valid/fb_ready     FIFO head handshake
//   kbd_code/kbd_valid    keyboard decoder code and load strobe
// Handshake: the video side takes the head in any cycle where fb_valid and
//   fb_ready are both high; while fb_valid is high and fb_ready low the head
//   (fb_addr/fb_data) holds steady. fb_ready has no effect while fb_valid is low.
// -----------------------------------------------------------------------------
module hack_mem_ctrl
  import hack_mem_ctrl_pkg::*;
#(
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] SCREEN_BASE = DEF_SCREEN_BASE,
  parameter logic [ADDR_W-1:0] KBD_ADDR    = DEF_KBD_ADDR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [WORD_W-1:0]    cpu_wdata,
  input  logic                 cpu_we,
  output logic [WORD_W-1:0]    cpu_rdata,
  output logic                 cpu_stall,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [WORD_W-1:0]    ram_wdata,
  output logic                 ram_we,
  input  logic [WORD_W-1:0]    ram_rdata,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [WORD_W-1:0]    fb_data,
  output logic                 fb_valid,
  input  logic                 fb_ready,
  input  logic [WORD_W-1:0]    kbd_code,
  input  logic                 kbd_valid
);

  region_e               w_region;
  logic                  w_scr_wr;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;
  logic [FB_ADDR_W-1:0]  w_scr_offset;
  logic [FIFO_W-1:0]     w_head;

  region_e               r_rd_region;
  logic [WORD_W-1:0]     r_kbd;
  logic [WORD_W-1:0]     r_kbd_rd;

  assign w_region     = decode_region(cpu_addr, KBD_ADDR);
  assign w_scr_offset = cpu_addr[FB_ADDR_W-1:0] - SCREEN_BASE[FB_ADDR_W-1:0];

  // Full is taken before this cycle's pop: a full FIFO never writes through.
  assign w_scr_wr  = cpu_we && (w_region == RGN_SCREEN);
  assign w_push    = w_scr_wr && !w_full;
  assign cpu_stall = w_scr_wr && w_full;

  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_we    = (cpu_we && (w_region == RGN_RAM)) || w_push;

  hack_wr_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({w_scr_offset, cpu_wdata}),
    .i_pop   (fb_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign fb_valid = !w_empty;
  assign fb_addr  = w_head[FIFO_W-1:WORD_W];
  assign fb_data  = w_head[WORD_W-1:0];

  // r_kbd_rd snapshots the keyboard register alongside the read address so a
  // KBD read coinciding with kbd_valid returns the value from before the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_region <= RGN_NONE;
      r_kbd       <= '0;
      r_kbd_rd    <= '0;
    end else begin
      r_rd_region <= w_region;
      r_kbd_rd    <= r_kbd;
      if (kbd_valid) r_kbd <= kbd_code;
    end
  end

  // ram_rdata is already one cycle late, so steering it with the registered
  // region lines it up with the other sources.
  always_comb begin
    cpu_rdata = '0;
    case (r_rd_region)
      RGN_RAM, RGN_SCREEN: cpu_rdata = ram_rdata;
      RGN_KBD:             cpu_rdata = r_kbd_rd;
      default:             cpu_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hack_mem_ctrl.sv
module tb_hack_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [12:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_valid;
  logic        fb_ready;
  logic [15:0] kbd_code;
  logic        kbd_valid;

  int errors = 0;
  int checks = 0;
  logic [28:0] exp_q[$];
  logic [28:0] exp_head;

  hack_mem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_valid  (fb_valid),
    .fb_ready  (fb_ready),
    .kbd_code  (kbd_code),
    .kbd_valid (kbd_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM model: read-before-write, one-cycle read latency. Filled with a
  // non-zero pattern so a stray RAM read on an unmapped/KBD address shows up.
  logic [15:0] mem [0:32767];
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'hBEEF;
    ram_rdata = 16'h0;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [14:0] a, input logic we, input logic [15:0] d);
    cpu_addr  = a;
    cpu_we    = we;
    cpu_wdata = d;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fb_ready = 1'b0; kbd_valid = 1'b0; kbd_code = 16'h0;
    cpu_addr = 15'h0; cpu_we = 1'b0; cpu_wdata = 16'h0;
    repeat (3) tick();
    checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", cpu_rdata); end
    checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL reset_fb_valid: got %b expected 0", fb_valid); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
    rst_n = 1'b1;
    tick();
    // Load keyboard and queue two screen writes, then reset mid-write.
    kbd_valid = 1'b1; kbd_code = 16'h0055;
    drive(15'h4000, 1'b1, 16'h1111);
    tick();
    kbd_valid = 1'b0;
    drive(15'h4001, 1'b1, 16'h2222);
    tick();
    drive(15'h6000, 1'b0, 16'h0);
    tick();
    checks++; if (cpu_rdata !== 16'h0055) begin errors++; $display("FAIL pre_reset_kbd: got %h expected 0055", cpu_rdata); end
    checks++; if (fb_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_fb_valid: got %b expected 1", fb_valid); end
    drive(15'h4002, 1'b1, 16'h3333);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL async_fb_valid: got %b expected 0", fb_valid); end
    checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL async_rdata: got %h expected 0000", cpu_rdata); end
    cpu_we = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL post_reset_ram_we: got %b expected 0", ram_we); end
    drive(15'h6000, 1'b0, 16'h0);
    tick();
    checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL post_reset_kbd: got %h expected 0000", cpu_rdata); end
    checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL post_reset_fifo_empty: got %b expected 0", fb_valid); end
  endtask

  task automatic test_ram();
    drive(15'h0010, 1'b1, 16'h1234);
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL ram_we_pulse: got %b expected 1", ram_we); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL ram_no_stall: got %b expected 0", cpu_stall); end
    tick();
    checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL ram_no_push: got %b expected 0", fb_valid); end
    drive(15'h0010, 1'b0, 16'h0);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ram_read_we: got %b expected 0", ram_we); end
    tick();
    checks++; if (cpu_rdata !== 16'h1234) begin errors++; $display("FAIL ram_readback: got %h expected 1234", cpu_rdata); end
  endtask

  task automatic test_fifo_full();
    fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(15'h4000 + 15'(i), 1'b1, 16'hA000 + 16'(i));
      if (i < 4) begin
        exp_q.push_back({13'(i), 16'hA000 + 16'(i)});
        checks++; if (ram_we !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("FAIL scr_push_%0d: ram_we=%b stall=%b expected ram_we=1 stall=0", i, ram_we, cpu_stall); end
      end else begin
        exp_q.push_back({13'd4, 16'hA004});
        checks++; if (ram_we !== 1'b0 || cpu_stall !== 1'b1) begin errors++; $display("FAIL scr_full_stall: ram_we=%b stall=%b expected ram_we=0 stall=1", ram_we, cpu_stall); end
      end
      tick();
    end
    checks++; if ({fb_addr, fb_data} !== {13'd0, 16'hA000}) begin errors++; $display("FAIL head_stable: got %h/%h expected 0000/a000", fb_addr, fb_data); end
    fb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) cpu_we = 1'b0;
      #1;
      exp_head = exp_q.pop_front();
      checks++; if (fb_valid !== 1'b1 || {fb_addr, fb_data} !== exp_head) begin errors++; $display("FAIL pop_order_%0d: valid=%b got %h/%h expected %h/%h", k, fb_valid, fb_addr, fb_data, exp_head[28:16], exp_head[15:0]); end
      if (k == 0) begin
        checks++; if (cpu_stall !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL full_before_pop: stall=%b ram_we=%b expected stall=1 ram_we=0", cpu_stall, ram_we); end
      end
      if (k == 1) begin
        checks++; if (cpu_stall !== 1'b0 || ram_we !== 1'b1) begin errors++; $display("FAIL retry_accept: stall=%b ram_we=%b expected stall=0 ram_we=1", cpu_stall, ram_we); end
      end
      tick();
    end
    checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL fifo_drained: got %b expected 0", fb_valid); end
    fb_ready = 1'b0;
  endtask

  task automatic test_kbd();
    kbd_valid = 1'b1; kbd_code = 16'd65;
    drive(15'h6000, 1'b0, 16'h0);
    tick();
    kbd_valid = 1'b0;
    checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL kbd_same_cycle: got %h expected 0000", cpu_rdata); end
    tick();
    checks++; if (cpu_rdata !== 16'd65) begin errors++; $display("FAIL kbd_next_read: got %h expected 0041", cpu_rdata); end
    drive(15'h6000, 1'b1, 16'hFFFF);
    checks++; if (ram_we !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL kbd_write_dropped: ram_we=%b stall=%b expected 0/0", ram_we, cpu_stall); end
    tick();
    drive(15'h6000, 1'b0, 16'h0);
    tick();
    checks++; if (cpu_rdata !== 16'd65) begin errors++; $display("FAIL kbd_unchanged: got %h expected 0041", cpu_rdata); end
  endtask

  task automatic test_unmapped();
    drive(15'h6001, 1'b0, 16'h0);
    tick();
    checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL read_6001: got %h expected 0000", cpu_rdata); end
    drive(15'h6001, 1'b1, 16'h5A5A);
    checks++; if (ram_we !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL write_6001: ram_we=%b stall=%b expected 0/0", ram_we, cpu_stall); end
    drive(15'h7FFF, 1'b1, 16'hA5A5);
    checks++; if (ram_we !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL write_7fff: ram_we=%b stall=%b expected 0/0", ram_we, cpu_stall); end
    drive(15'h6000, 1'b0, 16'h0);
    tick();
    drive(15'h7FFF, 1'b0, 16'h0);
    tick();
    checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL read_7fff: got %h expected 0000", cpu_rdata); end
  endtask

  task automatic test_back_to_back();
    fb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(15'h5FF8 + 15'(i), 1'b1, 16'hC000 + 16'(i));
      checks++; if (cpu_stall !== 1'b0 || ram_we !== 1'b1) begin errors++; $display("FAIL b2b_accept_%0d: stall=%b ram_we=%b expected 0/1", i, cpu_stall, ram_we); end
      if (i > 0) begin
        checks++; if (fb_valid !== 1'b1 || fb_addr !== 13'h1FF8 + 13'(i - 1) || fb_data !== 16'hC000 + 16'(i - 1)) begin
          errors++; $display("FAIL b2b_head_%0d: valid=%b got %h/%h expected %h/%h", i, fb_valid, fb_addr, fb_data, 13'h1FF8 + 13'(i - 1), 16'hC000 + 16'(i - 1));
        end
      end
      tick();
    end
    drive(15'h0, 1'b0, 16'h0);
    checks++; if (fb_valid !== 1'b1 || fb_addr !== 13'h1FFF) begin errors++; $display("FAIL b2b_last_head: valid=%b got %h expected 1fff", fb_valid, fb_addr); end
    tick();
    checks++; if (fb_valid !== 1'b0) begin errors++; $display("FAIL b2b_single_entry: got %b expected 0", fb_valid); end
    fb_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_full();
    test_kbd();
    test_unmapped();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
